cas_fsk_player: RTL and testbench

- Cassette playback engine between the tape image buffer (COCO_SRAM, loaded from the CAS download) and the CoCo3 cassette input.
- Captures the downloaded image length and fetches bytes from the buffer.
- Serialises each byte LSB-first as CoCo FSK: bit 0 = one 1200 Hz cycle, bit 1 = one 2400 Hz cycle.
- Playback is gated by the motor relay; the block supports pause, rewind and end-of-tape.

---
 rtl/cas_fsk_player.sv | 160 ++++++++++++++++
 tb/tb_cas_fsk_player.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cas_fsk_player.sv
// Cassette playback engine for the CoCo3 core.
// Reads the downloaded tape image back out of the buffer and plays each byte
// LSB-first as FSK: a 0-bit is one 1200 Hz cycle, a 1-bit is one 2400 Hz cycle.
// The motor relay gates playback. Rewind and a fresh download return the
// player to tape start. The player stops at end of tape.
module cas_fsk_player #(
    parameter int HALF_1200 = 23864,
    parameter int HALF_2400 = 11932,
    parameter int AW        = 16
) (
    input  logic          clk,
    input  logic          RESET_N,
    input  logic          ld_active,
    input  logic          ld_wr,
    input  logic [AW-1:0] ld_addr,
    input  logic          en,
    input  logic          rewind,
    output logic [AW-1:0] mem_addr,
    output logic          mem_rd,
    input  logic [7:0]    mem_data,
    output logic          casdout,
    output logic          playing,
    output logic          eot
);

    localparam int HMAX = (HALF_1200 > HALF_2400) ? HALF_1200 : HALF_2400;
    localparam int HW   = $clog2(HMAX + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LATCH = 3'd2;
    localparam logic [2:0] S_HI    = 3'd3;
    localparam logic [2:0] S_LO    = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state;
    logic [AW:0]   tape_len;
    logic          ld_active_q;
    logic [7:0]    shift;
    logic [2:0]    bitcnt;
    logic [HW-1:0] halfcnt;
    logic          rd_q;
    logic [HW-1:0] half_last;
    logic          half_end;
    logic [AW:0]   next_count;

    // The current bit selects the half-period length; the byte counter is one
    // bit wider than the address so a full 2^AW image still reaches DONE.
    assign half_last  = shift[0] ? HW'(HALF_2400 - 1) : HW'(HALF_1200 - 1);
    assign half_end   = (halfcnt == half_last);
    assign next_count = {1'b0, mem_addr} + (AW+1)'(1);
    assign playing    = en && (state != S_IDLE) && (state != S_DONE);

    // Track the image length from download writes; a new download starts from zero.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            tape_len    <= '0;
            ld_active_q <= 1'b0;
        end else begin
            ld_active_q <= ld_active;
            if (ld_wr)
                tape_len <= {1'b0, ld_addr} + (AW+1)'(1);
            else if (ld_active && !ld_active_q)
                tape_len <= '0;
        end
    end

    // Playback sequencer: fetch a byte, then emit one high/low half pair per bit.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            casdout  <= 1'b0;
            eot      <= 1'b0;
            shift    <= '0;
            bitcnt   <= '0;
            halfcnt  <= '0;
            rd_q     <= 1'b0;
        end else if (ld_active || rewind) begin
            state    <= S_IDLE;
            mem_addr <= '0;
            mem_rd   <= 1'b0;
            casdout  <= 1'b0;
            eot      <= 1'b0;
            rd_q     <= 1'b0;
        end else begin
            mem_rd <= 1'b0;
            rd_q   <= mem_rd;
            case (state)
                S_IDLE: begin
                    if (en) begin
                        if (tape_len == '0) begin
                            state <= S_DONE;
                            eot   <= 1'b1;
                        end else begin
                            state  <= S_FETCH;
                            mem_rd <= 1'b1;
                        end
                    end
                end
                S_FETCH: begin
                    state <= S_LATCH;
                end
                S_LATCH: begin
                    if (rd_q) begin
                        shift   <= mem_data;
                        bitcnt  <= '0;
                        halfcnt <= '0;
                    end
                    if (en) begin
                        state   <= S_HI;
                        casdout <= 1'b1;
                    end
                end
                S_HI: begin
                    if (en) begin
                        if (half_end) begin
                            halfcnt <= '0;
                            state   <= S_LO;
                            casdout <= 1'b0;
                        end else begin
                            halfcnt <= halfcnt + HW'(1);
                        end
                    end
                end
                S_LO: begin
                    if (en) begin
                        if (!half_end) begin
                            halfcnt <= halfcnt + HW'(1);
                        end else if (bitcnt != 3'd7) begin
                            halfcnt <= '0;
                            shift   <= shift >> 1;
                            bitcnt  <= bitcnt + 3'd1;
                            state   <= S_HI;
                            casdout <= 1'b1;
                        end else begin
                            halfcnt  <= '0;
                            mem_addr <= next_count[AW-1:0];
                            if (next_count == tape_len) begin
                                state <= S_DONE;
                                eot   <= 1'b1;
                            end else begin
                                state  <= S_FETCH;
                                mem_rd <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    casdout <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cas_fsk_player.sv
// Testbench for cas_fsk_player with short half-periods and a 3-bit address.
// A waveform model expands each tape byte into its expected per-cycle outputs.
// The bench compares the player against that model on every cycle. Literal
// span and strobe counts pin down the model itself.
module tb_cas_fsk_player;

    localparam int H1 = 4;
    localparam int H0 = 8;

    logic       clk;
    logic       RESET_N;
    logic       ld_active;
    logic       ld_wr;
    logic [2:0] ld_addr;
    logic       en;
    logic       rewind;
    logic [2:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       casdout;
    logic       playing;
    logic       eot;

    int vectors;
    int miscompares;

    logic [7:0] sram [0:7];
    logic [7:0] img  [0:7];
    int modelLen;

    bit expCas[$];
    bit expRd[$];
    int expAddr[$];
    bit expEot[$];
    bit modelOn;
    int idx;
    int restartReq;
    int restartSeen;

    cas_fsk_player #(.HALF_1200(H0), .HALF_2400(H1), .AW(3)) dut (
        .clk(clk),
        .RESET_N(RESET_N),
        .ld_active(ld_active),
        .ld_wr(ld_wr),
        .ld_addr(ld_addr),
        .en(en),
        .rewind(rewind),
        .mem_addr(mem_addr),
        .mem_rd(mem_rd),
        .mem_data(mem_data),
        .casdout(casdout),
        .playing(playing),
        .eot(eot)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Tape buffer: data appears one clock after the read strobe.
    always @(posedge clk) begin
        if (mem_rd) mem_data <= sram[mem_addr];
    end

    task automatic checkOutput(input string name, input int act, input int expv);
        vectors++;
        if (act != expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic pushExp(input bit c, input bit r, input int a, input bit e);
        expCas.push_back(c);
        expRd.push_back(r);
        expAddr.push_back(a);
        expEot.push_back(e);
    endtask

    // Expected waveform: per byte a read cycle, a latch cycle, then per bit
    // h cycles high and h cycles low; finally the parked end-of-tape state.
    task automatic buildModel();
        expCas.delete();
        expRd.delete();
        expAddr.delete();
        expEot.delete();
        for (int b = 0; b < modelLen; b++) begin
            pushExp(1'b0, 1'b1, b % 8, 1'b0);
            pushExp(1'b0, 1'b0, b % 8, 1'b0);
            for (int k = 0; k < 8; k++) begin
                int h;
                h = sram[b][k] ? H1 : H0;
                for (int j = 0; j < h; j++) pushExp(1'b1, 1'b0, b % 8, 1'b0);
                for (int j = 0; j < h; j++) pushExp(1'b0, 1'b0, b % 8, 1'b0);
            end
        end
        pushExp(1'b0, 1'b0, modelLen % 8, 1'b1);
    endtask

    // Model time only advances on clocks where the motor runs and nothing forces a stop.
    always @(posedge clk) begin
        if (restartReq != restartSeen) begin
            restartSeen <= restartReq;
            idx         <= -1;
        end else if (modelOn && en && !rewind && !ld_active && idx < expCas.size() - 1) begin
            idx <= idx + 1;
        end
    end

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge clk) begin
        if (modelOn && idx >= 0) begin
            checkOutput("model.casdout", int'(casdout), int'(expCas[idx]));
            checkOutput("model.mem_rd", int'(mem_rd), int'(expRd[idx]));
            checkOutput("model.mem_addr", int'(mem_addr), expAddr[idx]);
            checkOutput("model.eot", int'(eot), int'(expEot[idx]));
            checkOutput("model.playing", int'(playing), (en && idx < expCas.size() - 1) ? 1 : 0);
        end
    end

    task automatic doReset();
        modelOn   = 1'b0;
        en        = 1'b0;
        rewind    = 1'b0;
        ld_active = 1'b0;
        ld_wr     = 1'b0;
        ld_addr   = '0;
        @(negedge clk);
        #1 RESET_N = 1'b0;
        @(negedge clk);
        checkOutput("reset.mem_addr", int'(mem_addr), 0);
        checkOutput("reset.mem_rd", int'(mem_rd), 0);
        checkOutput("reset.casdout", int'(casdout), 0);
        checkOutput("reset.playing", int'(playing), 0);
        checkOutput("reset.eot", int'(eot), 0);
        #1 RESET_N = 1'b1;
    endtask

    // Download img[0..n-1] into the buffer through the loader port.
    task automatic applyStimulus(input int n);
        modelOn = 1'b0;
        @(negedge clk);
        #1 ld_active = 1'b1;
        @(negedge clk);
        #1;
        for (int i = 0; i < n; i++) begin
            ld_addr = 3'(i);
            ld_wr   = 1'b1;
            sram[i] = img[i];
            @(negedge clk);
            #1 ld_wr = 1'b0;
            @(negedge clk);
            #1;
        end
        ld_active = 1'b0;
        modelLen  = n;
        @(negedge clk);
        #1;
    endtask

    task automatic startModel();
        @(negedge clk);
        #1;
        buildModel();
        restartReq++;
        modelOn = 1'b1;
        @(negedge clk);
        #1;
    endtask

    // Count falling edges from the first read strobe to end of tape, and strobes seen.
    task automatic runToEot(input int limit, input string name, output int span, output int rds);
        int first;
        bit seen;
        first = -1;
        seen  = 1'b0;
        span  = -1;
        rds   = 0;
        for (int c = 0; c < limit && !seen; c++) begin
            @(negedge clk);
            if (mem_rd) begin
                rds++;
                if (first < 0) first = c;
            end
            if (eot) begin
                seen = 1'b1;
                span = c - first;
            end
        end
        checkOutput({name, ".eotReached"}, int'(seen), 1);
    endtask

    // Watchdog so a stuck run still reports.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish, miscompares so far %0d", miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int span;
        int rds;
        int cyc;
        int first;
        int hi;
        int hiAfter;
        bit found;

        vectors     = 0;
        miscompares = 0;
        modelOn     = 1'b0;
        restartReq  = 0;
        restartSeen = 0;
        idx         = -1;
        modelLen    = 0;
        RESET_N     = 1'b1;
        en          = 1'b0;
        rewind      = 1'b0;
        ld_active   = 1'b0;
        ld_wr       = 1'b0;
        ld_addr     = '0;
        for (int i = 0; i < 8; i++) begin
            sram[i] = 8'h00;
            img[i]  = 8'h00;
        end

        // Single byte 0x01: one short bit then seven long bits.
        doReset();
        img[0] = 8'h01;
        applyStimulus(1);
        startModel();
        en = 1'b1;
        runToEot(400, "single", span, rds);
        checkOutput("single.span", span, 122);
        checkOutput("single.rdCount", rds, 1);
        @(negedge clk);
        checkOutput("single.eot", int'(eot), 1);
        checkOutput("single.playing", int'(playing), 0);
        checkOutput("single.casdout", int'(casdout), 0);

        // Length capture: five bytes, then a second download of two.
        doReset();
        img[0] = 8'h01; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04; img[4] = 8'h05;
        applyStimulus(5);
        startModel();
        en = 1'b1;
        runToEot(1500, "len5", span, rds);
        checkOutput("len5.span", span, 594);
        checkOutput("len5.rdCount", rds, 5);
        #1 en = 1'b0;
        img[0] = 8'h80; img[1] = 8'h7E;
        applyStimulus(2);
        checkOutput("len2.eotCleared", int'(eot), 0);
        startModel();
        en = 1'b1;
        runToEot(600, "len2", span, rds);
        checkOutput("len2.span", span, 204);
        checkOutput("len2.rdCount", rds, 2);

        // Pause three clocks into the first high half of a 0-bit.
        doReset();
        img[0] = 8'h00;
        applyStimulus(1);
        startModel();
        en = 1'b1;
        cyc = 0; first = -1; hi = 0;
        while (hi < 3 && cyc < 50) begin
            @(negedge clk);
            cyc++;
            if (mem_rd && first < 0) first = cyc;
            if (casdout) hi++;
        end
        checkOutput("pause.reachedHigh", hi, 3);
        #1 en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            cyc++;
            checkOutput("pause.casdoutHeld", int'(casdout), 1);
            checkOutput("pause.noRead", int'(mem_rd), 0);
        end
        #1 en = 1'b1;
        hiAfter = 0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (casdout) hiAfter++;
            else found = 1'b1;
        end
        checkOutput("pause.highAfterResume", hiAfter, 5);
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            if (eot) found = 1'b1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        checkOutput("pause.eotReached", int'(found), 1);
        checkOutput("pause.span", cyc - first, 150);

        // Rewind during the second byte of a four-byte tape.
        doReset();
        img[0] = 8'hFF; img[1] = 8'h00; img[2] = 8'h0F; img[3] = 8'hA5;
        applyStimulus(4);
        startModel();
        en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 600 && !found; c++) begin
            @(negedge clk);
            if (mem_addr == 3'd1 && casdout) found = 1'b1;
        end
        checkOutput("rewind.reachByte2", int'(found), 1);
        #1;
        modelOn = 1'b0;
        rewind  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("rewind.mem_addr", int'(mem_addr), 0);
            checkOutput("rewind.casdout", int'(casdout), 0);
            checkOutput("rewind.eot", int'(eot), 0);
            checkOutput("rewind.mem_rd", int'(mem_rd), 0);
            checkOutput("rewind.playing", int'(playing), 0);
        end
        #1;
        startModel();
        rewind = 1'b0;
        runToEot(1200, "rewind", span, rds);
        checkOutput("rewind.span", span, 392);
        checkOutput("rewind.rdCount", rds, 4);

        // Empty tape: motor on goes straight to end of tape.
        doReset();
        modelLen = 0;
        startModel();
        en = 1'b1;
        @(negedge clk);
        checkOutput("empty.eot", int'(eot), 1);
        checkOutput("empty.playing", int'(playing), 0);
        rds = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (mem_rd) rds++;
        end
        checkOutput("empty.rdCount", rds, 0);

        // Asynchronous reset in the middle of the second byte.
        doReset();
        img[0] = 8'h55; img[1] = 8'hAA;
        applyStimulus(2);
        startModel();
        en = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 400 && !found; c++) begin
            @(negedge clk);
            if (mem_addr == 3'd1 && casdout) found = 1'b1;
        end
        checkOutput("areset.reachByte2", int'(found), 1);
        modelOn = 1'b0;
        #1 RESET_N = 1'b0;
        #1;
        checkOutput("areset.mem_addr", int'(mem_addr), 0);
        checkOutput("areset.casdout", int'(casdout), 0);
        checkOutput("areset.mem_rd", int'(mem_rd), 0);
        checkOutput("areset.playing", int'(playing), 0);
        checkOutput("areset.eot", int'(eot), 0);
        @(negedge clk);
        #1 RESET_N = 1'b1;
        en = 1'b0;

        // Full-size image: address wraps, end of tape still reached.
        doReset();
        for (int i = 0; i < 8; i++) img[i] = 8'hFF;
        applyStimulus(8);
        startModel();
        en = 1'b1;
        runToEot(1200, "wrap", span, rds);
        checkOutput("wrap.span", span, 528);
        checkOutput("wrap.rdCount", rds, 8);
        @(negedge clk);
        checkOutput("wrap.mem_addr", int'(mem_addr), 0);
        checkOutput("wrap.eot", int'(eot), 1);

        modelOn = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
